// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART receive and transmit paths: the deframer
// state encoding, the oversampling constants, and the baud divider
// calculation. The transmitter uses the same divider function, so both
// directions derive their bit timing in the same way.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Number of ticks in one bit period. The deframer's counters assume this value.
    localparam int OVERSAMPLE = 16;
    // Tick count at the middle of the start bit, measured from the detected edge.
    localparam int START_MID  = 7;
    // Tick count that ends a full bit period.
    localparam int BIT_LAST   = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // System clocks per oversampling tick. Integer division truncates the result.
    function automatic int calc_div(input int clk_fr, input int baud_rate);
        return clk_fr / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer_if
//
// Groups the signals between the serial line, the deframer, and the debug unit.
//   i_rx             serial line, idle high, asynchronous to the system clock
//   i_rx_reset       level; clears the ready and overrun flags while high
//   o_rx_data        last byte received with a good stop bit
//   o_rx_flag_ready  sticky; a good byte is waiting
//   o_rx_frame_error one-cycle pulse when a stop bit is sampled low
//   o_rx_overrun     sticky; a good byte arrived while ready was still set
//   o_rx_busy        deframer is not idle
//   dbg_state        current deframer state, for observation only
//
// Handshake: this is not a valid/ready pair. A byte is offered when
// o_rx_flag_ready is set, together with o_rx_data in the same cycle. The
// consumer acknowledges it by holding i_rx_reset high for at least one clock
// edge. The receiver cannot be stalled. A byte that completes while the flag
// is still set replaces o_rx_data and raises o_rx_overrun.
// -----------------------------------------------------------------------------
interface uart_rx_deframer_if #(
    parameter int SIZE_TRAMA = 8
) ();
    import uart_pkg::*;

    logic                  i_rx;
    logic                  i_rx_reset;
    logic [SIZE_TRAMA-1:0] o_rx_data;
    logic                  o_rx_flag_ready;
    logic                  o_rx_frame_error;
    logic                  o_rx_overrun;
    logic                  o_rx_busy;
    state_t                dbg_state;

    // Deframer side.
    modport slave (
        input  i_rx,
        input  i_rx_reset,
        output o_rx_data,
        output o_rx_flag_ready,
        output o_rx_frame_error,
        output o_rx_overrun,
        output o_rx_busy,
        output dbg_state
    );

    // Line driver / debug unit side.
    modport master (
        output i_rx,
        output i_rx_reset,
        input  o_rx_data,
        input  o_rx_flag_ready,
        input  o_rx_frame_error,
        input  o_rx_overrun,
        input  o_rx_busy,
        input  dbg_state
    );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//
// Produces one-cycle ticks at 16x the baud rate from a free-running divider.
//   i_clk    system clock
//   i_reset  asynchronous, active-high reset
//   o_tick   high for one cycle after each divider period
// The tick is registered so that it is 0 during reset even when DIV is 1.
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FR    = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int DIV = calc_div(CLK_FR, BAUD_RATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: CLK_FR / (BAUD_RATE*16) must be at least 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == CW'(DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        tick_d = wrap;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// 8N1 UART receiver with 16x oversampling for the debug path.
//   i_clk    system clock; all logic uses the rising edge
//   i_reset  asynchronous, active-high reset; drops any partial frame
//   rx_if    serial input, acknowledge input, data/flag/error/busy outputs
//
// The start bit is confirmed at its midpoint. After that, each data bit and
// the stop bit are sampled one full bit period apart, which places every
// sample near the middle of its bit. IDLE is re-entered at mid stop bit, so a
// following start edge is not missed.
// -----------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_FR     = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int SIZE_TRAMA = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    uart_rx_deframer_if.slave  rx_if
);

    localparam int NBW = (SIZE_TRAMA > 1) ? $clog2(SIZE_TRAMA) : 1;

    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_os
        $error("uart_rx_deframer: only OVERSAMPLE = 16 is supported");
    end

    logic tick;

    uart_baud_tick #(
        .CLK_FR    (CLK_FR),
        .BAUD_RATE (BAUD_RATE)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (tick)
    );

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NBW-1:0]        nbit_q, nbit_d;
    logic [SIZE_TRAMA-1:0] shreg_q, shreg_d;
    logic [SIZE_TRAMA-1:0] data_q, data_d;
    logic                  flag_q, flag_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        sync1_d = rx_if.i_rx;
        rx_s_d  = sync1_q;
        cnt_d   = cnt_q;
        nbit_d  = nbit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        flag_d  = flag_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;

        // An acknowledge clears the flags. A frame that completes in the same
        // cycle is applied after this and overrides it.
        if (rx_if.i_rx_reset) begin
            flag_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == 4'(START_MID)) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            nbit_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    // The counter wraps from 15 to 0, which starts the next bit period.
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(BIT_LAST)) begin
                        // Shift in from the MSB side so the first bit ends up at bit 0.
                        shreg_d = {rx_s_q, shreg_q[SIZE_TRAMA-1:1]};
                        if (nbit_q == NBW'(SIZE_TRAMA - 1)) begin
                            state_d = STOP;
                            cnt_d   = '0;
                        end else begin
                            nbit_d = nbit_q + NBW'(1);
                        end
                    end
                end
                STOP: begin
                    if (cnt_q == 4'(BIT_LAST)) begin
                        state_d = IDLE;
                        if (rx_s_q) begin
                            data_d = shreg_q;
                            flag_d = 1'b1;
                            if (flag_q && !rx_if.i_rx_reset) begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            cnt_q   <= '0;
            nbit_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            cnt_q   <= cnt_d;
            nbit_q  <= nbit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.o_rx_data        = data_q;
    assign rx_if.o_rx_flag_ready  = flag_q;
    assign rx_if.o_rx_frame_error = ferr_q;
    assign rx_if.o_rx_overrun     = ovr_q;
    assign rx_if.o_rx_busy        = (state_q != IDLE);
    assign rx_if.dbg_state        = state_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// CLK_FR=160 and BAUD_RATE=10 give one tick per clock, so one bit lasts 16
// clocks. A frame's start edge is driven at the falling edge counted as c0.
// The first rising edge that samples it is c0+1. Two synchronizer stages
// follow, so the receiver first sees the low level at edge c0+3. The frame
// then completes 152 ticks later, at edge c0+155.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int FRAME_DONE = 155;
  localparam int SEEN_EDGE  = 3;
  localparam int GLITCH_END = 11;   // SEEN_EDGE + 8 ticks to mid start bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_deframer_if #(.SIZE_TRAMA(8)) rx_if ();

  uart_rx_deframer #(
    .CLK_FR     (160),
    .BAUD_RATE  (10),
    .SIZE_TRAMA (8),
    .OVERSAMPLE (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .rx_if   (rx_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Scoreboard: bytes expected from good frames, in order.
  logic [7:0] exp_q[$];

  typedef enum int {EV_NONE, EV_GLITCH, EV_GOOD, EV_BAD} ev_t;
  ev_t ev_kind  = EV_NONE;
  int  ev_start = 0;
  int  ev_end   = 0;
  int  last_c0  = 0;

  // Behavioural model of the outputs.
  logic [7:0] m_data = '0;
  logic       m_flag = 1'b0;
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_busy = 1'b0;

  // Observations used by the directed checks.
  int   rise_cnt    = 0;
  int   rise_cyc    = 0;
  int   ferr_cycles = 0;
  bit   ovr_seen    = 1'b0;
  bit   busy_seen   = 1'b0;
  logic prev_flag   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic       clr;
    logic       nf;
    logic       no;
    logic [7:0] nb;
    if (rst) begin
      m_data = '0; m_flag = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
      ev_kind = EV_NONE;
      exp_q.delete();
    end else begin
      clr    = rx_if.i_rx_reset;
      m_busy = (ev_kind != EV_NONE) && (cyc >= ev_start) && (cyc < ev_end);
      m_ferr = 1'b0;
      nf     = clr ? 1'b0 : m_flag;
      no     = clr ? 1'b0 : m_ovr;
      if (ev_kind != EV_NONE && cyc == ev_end) begin
        if (ev_kind == EV_GOOD) begin
          nb = m_data;
          if (exp_q.size() > 0) nb = exp_q.pop_front();
          if (m_flag && !clr) no = 1'b1;
          nf     = 1'b1;
          m_data = nb;
        end else if (ev_kind == EV_BAD) begin
          m_ferr = 1'b1;
        end
        ev_kind = EV_NONE;
      end
      m_flag = nf;
      m_ovr  = no;
    end
  endtask

  // Compare process: update the model at the rising edge, then check the outputs 2 ns later.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_step();
      #2;
      check("data",  rx_if.o_rx_data,        m_data);
      check("flag",  rx_if.o_rx_flag_ready,  m_flag);
      check("ferr",  rx_if.o_rx_frame_error, m_ferr);
      check("ovr",   rx_if.o_rx_overrun,     m_ovr);
      check("busy",  rx_if.o_rx_busy,        m_busy);
      if (rx_if.o_rx_flag_ready === 1'b1 && prev_flag !== 1'b1) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      prev_flag = rx_if.o_rx_flag_ready;
      if (rx_if.o_rx_frame_error === 1'b1) ferr_cycles++;
      if (rx_if.o_rx_overrun === 1'b1) ovr_seen = 1'b1;
      if (rx_if.o_rx_busy === 1'b1) busy_seen = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_flag();
    @(negedge clk);
    rx_if.i_rx_reset = 1'b1;
    @(negedge clk);
    rx_if.i_rx_reset = 1'b0;
  endtask

  // Drive one 8N1 frame. A low stop bit is released right after its mid-bit
  // sample so the idle line does not look like a new start edge.
  // clr_end raises i_rx_reset for the completion edge; abort_at >= 0 stops
  // driving partway through the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit clr_end, input int abort_at);
    int c0;
    int k;
    @(negedge clk);
    c0       = cyc;
    last_c0  = c0;
    ev_start = c0 + SEEN_EDGE;
    ev_end   = c0 + FRAME_DONE;
    ev_kind  = stop_bit ? EV_GOOD : EV_BAD;
    if (stop_bit) exp_q.push_back(b);
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_at) return;
      k = i / 16;
      if (k == 0)      rx_if.i_rx = 1'b0;
      else if (k <= 8) rx_if.i_rx = b[k-1];
      else             rx_if.i_rx = stop_bit ? 1'b1 : (i < 153 ? 1'b0 : 1'b1);
      rx_if.i_rx_reset = (clr_end && i == 154);
    end
    @(negedge clk);
    rx_if.i_rx       = 1'b1;
    rx_if.i_rx_reset = 1'b0;
  endtask

  task automatic send_glitch();
    int c0;
    @(negedge clk);
    c0       = cyc;
    ev_start = c0 + SEEN_EDGE;
    ev_end   = c0 + GLITCH_END;
    ev_kind  = EV_GLITCH;
    rx_if.i_rx = 1'b0;
    idle(4);
    rx_if.i_rx = 1'b1;
    idle(20);
  endtask

  logic [7:0] stream [4];
  int         base;
  int         lat;

  initial begin
    stream[0] = 8'h00; stream[1] = 8'h23; stream[2] = 8'h00; stream[3] = 8'h20;
    rx_if.i_rx       = 1'b1;
    rx_if.i_rx_reset = 1'b0;
    rst              = 1'b1;
    idle(3);
    check("reset_data", rx_if.o_rx_data, 32'h0);
    check("reset_flag", rx_if.o_rx_flag_ready, 32'h0);
    check("reset_busy", rx_if.o_rx_busy, 32'h0);
    rst = 1'b0;
    idle(10);

    // Good frame.
    send_frame(8'h64, 1'b1, 1'b0, -1);
    idle(5);
    check("good_data", rx_if.o_rx_data, 32'h64);
    check("good_flag", rx_if.o_rx_flag_ready, 32'h1);
    check("good_ovr",  rx_if.o_rx_overrun, 32'h0);
    check("good_ferr_cycles", ferr_cycles, 32'h0);
    lat = rise_cyc - last_c0;
    check("good_latency_in_153_155", (lat >= 153 && lat <= 155), 32'h1);
    clear_flag();

    // Instruction stream, acknowledging each byte.
    base     = rise_cnt;
    ovr_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_frame(stream[i], 1'b1, 1'b0, -1);
      idle(3);
      check("stream_data", rx_if.o_rx_data, stream[i]);
      clear_flag();
    end
    check("stream_rises", rise_cnt - base, 32'd4);
    check("stream_no_ovr", ovr_seen, 32'h0);

    // Glitch rejection.
    busy_seen = 1'b0;
    send_glitch();
    check("glitch_busy_seen", busy_seen, 32'h1);
    check("glitch_idle", rx_if.o_rx_busy, 32'h0);
    check("glitch_data", rx_if.o_rx_data, 32'h20);
    check("glitch_flag", rx_if.o_rx_flag_ready, 32'h0);

    // Framing error.
    ferr_cycles = 0;
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    idle(5);
    check("ferr_pulse_width", ferr_cycles, 32'd1);
    check("ferr_data_kept", rx_if.o_rx_data, 32'h20);
    check("ferr_flag", rx_if.o_rx_flag_ready, 32'h0);

    // Overrun.
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    idle(3);
    check("ovr_data", rx_if.o_rx_data, 32'h22);
    check("ovr_set", rx_if.o_rx_overrun, 32'h1);
    clear_flag();
    idle(1);
    check("ovr_cleared", rx_if.o_rx_overrun, 32'h0);
    check("flag_cleared", rx_if.o_rx_flag_ready, 32'h0);

    // The second frame completes on the same edge as the acknowledge.
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    idle(3);
    check("simul_flag", rx_if.o_rx_flag_ready, 32'h1);
    check("simul_ovr", rx_if.o_rx_overrun, 32'h0);
    check("simul_data", rx_if.o_rx_data, 32'h22);
    clear_flag();

    // Reset during data bit 4 of 0xFF.
    send_frame(8'hFF, 1'b1, 1'b0, 88);
    rst        = 1'b1;
    rx_if.i_rx = 1'b1;
    #1;
    check("rst_data", rx_if.o_rx_data, 32'h0);
    check("rst_busy", rx_if.o_rx_busy, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(1);
    check("post_rst_data", rx_if.o_rx_data, 32'h0);
    check("post_rst_flag", rx_if.o_rx_flag_ready, 32'h0);
    check("post_rst_ovr", rx_if.o_rx_overrun, 32'h0);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle(5);
    check("after_rst_data", rx_if.o_rx_data, 32'h3C);
    check("after_rst_flag", rx_if.o_rx_flag_ready, 32'h1);
    check("after_rst_ovr", rx_if.o_rx_overrun, 32'h0);
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
